// File: rtl/ro_puf_ctrl_multi_if.sv
// ro_puf_ctrl_multi_if
// Bundles the controller's handshake and datapath signals between the RO-PUF
// evaluation controller and its surroundings (muxes, RO counters, RAM path).
//   master : controller side (drives challenge, RO/counter control, results)
//   slave  : environment side (drives start and the two counter values)
interface ro_puf_ctrl_multi_if #(
  parameter int N_PAIRS = 256,
  parameter int CHAL_W  = 8,
  parameter int CNT_W   = 16
);
  logic               start;
  logic [CNT_W-1:0]   count0;
  logic [CNT_W-1:0]   count1;
  logic [CHAL_W-1:0]  challenge;
  logic               roen;
  logic               counter_rst;
  logic               counter_en;
  logic               bit_valid;
  logic               bit_out;
  logic [CHAL_W-1:0]  bit_addr;
  logic [N_PAIRS-1:0] signature;
  logic [7:0]         tie_cnt;
  logic               busy;
  logic               done;

  modport master (
    input  start, count0, count1,
    output challenge, roen, counter_rst, counter_en, bit_valid, bit_out,
           bit_addr, signature, tie_cnt, busy, done
  );

  modport slave (
    output start, count0, count1,
    input  challenge, roen, counter_rst, counter_en, bit_valid, bit_out,
           bit_addr, signature, tie_cnt, busy, done
  );
endinterface

// File: rtl/ro_puf_ctrl_multi.sv
// ro_puf_ctrl_multi
// RO-PUF evaluation controller. For every challenge 0..N_PAIRS-1 it runs VOTES
// measurements (clear counters, gate them for WINDOW cycles, wait SETTLE cycles,
// compare count0 > count1), majority-votes the result, emits it as a RAM write
// strobe and collects it into an N_PAIRS-bit signature. Ties are counted.
// Ports:
//   clk  - system clock
//   rst  - asynchronous reset, active-low
//   bus  - ro_puf_ctrl_multi_if.master (start, count0/1 in; challenge, roen,
//          counter_rst, counter_en, bit_valid, bit_out, bit_addr, signature,
//          tie_cnt, busy, done out). All outputs are registered.
module ro_puf_ctrl_multi #(
  parameter int N_PAIRS = 256,
  parameter int CHAL_W  = 8,
  parameter int CNT_W   = 16,
  parameter int WINDOW  = 1000,
  parameter int SETTLE  = 2,
  parameter int VOTES   = 1
) (
  input  logic clk,
  input  logic rst,
  ro_puf_ctrl_multi_if.master bus
);

  localparam int WIN_W = $clog2(WINDOW + 1);
  localparam int SET_W = $clog2(SETTLE + 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_RUN    = 3'd2,
    S_SETTLE = 3'd3,
    S_SAMPLE = 3'd4,
    S_EMIT   = 3'd5
  } state_t;

  state_t             state_r, state_s;
  logic [CHAL_W-1:0]  chal_r, chal_s;
  logic [3:0]         vote_r, vote_s;
  logic [3:0]         ones_r, ones_s;
  logic [WIN_W-1:0]   win_r, win_s;
  logic [SET_W-1:0]   set_r, set_s;
  logic [7:0]         tie_r, tie_s;
  logic [N_PAIRS-1:0] sig_r, sig_s;

  logic               roen_r, roen_s;
  logic               crst_r, crst_s;
  logic               cen_r, cen_s;
  logic               bvalid_r, bvalid_s;
  logic               bout_r, bout_s;
  logic [CHAL_W-1:0]  baddr_r, baddr_s;
  logic               busy_r, busy_s;
  logic               done_r, done_s;
  logic               meas_s;

  // Next-state, datapath update and output decode of the evaluation FSM.
  // Outputs are decoded from the next state so the registered copies line up
  // with the state they belong to.
  always_comb begin
    state_s = state_r;
    chal_s  = chal_r;
    vote_s  = vote_r;
    ones_s  = ones_r;
    win_s   = win_r;
    set_s   = set_r;
    tie_s   = tie_r;
    sig_s   = sig_r;
    meas_s  = 1'b0;

    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          chal_s  = '0;
          vote_s  = 4'd0;
          ones_s  = 4'd0;
          tie_s   = 8'd0;
          sig_s   = '0;
          state_s = S_CLR;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_CLR: begin
        win_s   = '0;
        state_s = S_RUN;
      end
      S_RUN: begin
        if (win_r == WIN_W'(WINDOW - 1)) begin
          win_s   = '0;
          set_s   = '0;
          state_s = S_SETTLE;
        end else begin
          win_s = win_r + WIN_W'(1);
        end
      end
      S_SETTLE: begin
        if (set_r == SET_W'(SETTLE - 1)) begin
          set_s   = '0;
          state_s = S_SAMPLE;
        end else begin
          set_s = set_r + SET_W'(1);
        end
      end
      S_SAMPLE: begin
        // A tie resolves to 0 and is counted, saturating at 255.
        meas_s = (bus.count0 > bus.count1);
        if ((bus.count0 == bus.count1) && (tie_r != 8'hFF)) begin
          tie_s = tie_r + 8'd1;
        end else begin
          tie_s = tie_r;
        end
        ones_s = ones_r + {3'b000, meas_s};
        if (vote_r < 4'(VOTES - 1)) begin
          vote_s  = vote_r + 4'd1;
          state_s = S_CLR;
        end else begin
          state_s = S_EMIT;
        end
      end
      S_EMIT: begin
        sig_s[chal_r] = bout_r;
        if (chal_r == CHAL_W'(N_PAIRS - 1)) begin
          state_s = S_IDLE;
        end else begin
          chal_s  = chal_r + CHAL_W'(1);
          vote_s  = 4'd0;
          ones_s  = 4'd0;
          state_s = S_CLR;
        end
      end
      default: begin
        state_s = S_IDLE;
      end
    endcase

    roen_s   = 1'b0;
    crst_s   = 1'b0;
    cen_s    = 1'b0;
    bvalid_s = 1'b0;
    bout_s   = 1'b0;
    baddr_s  = '0;
    done_s   = 1'b0;
    busy_s   = (state_s != S_IDLE);

    case (state_s)
      S_CLR: begin
        roen_s = 1'b1;
        crst_s = 1'b1;
      end
      S_RUN: begin
        roen_s = 1'b1;
        cen_s  = 1'b1;
      end
      S_SETTLE, S_SAMPLE: begin
        roen_s = 1'b1;
      end
      S_EMIT: begin
        bvalid_s = 1'b1;
        bout_s   = (ones_s > 4'(VOTES / 2));
        baddr_s  = chal_s;
        done_s   = (chal_s == CHAL_W'(N_PAIRS - 1));
      end
      default: begin
        roen_s = 1'b0;
      end
    endcase
  end

  // State, datapath and registered-output flops with asynchronous clear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r  <= S_IDLE;
      chal_r   <= '0;
      vote_r   <= 4'd0;
      ones_r   <= 4'd0;
      win_r    <= '0;
      set_r    <= '0;
      tie_r    <= 8'd0;
      sig_r    <= '0;
      roen_r   <= 1'b0;
      crst_r   <= 1'b0;
      cen_r    <= 1'b0;
      bvalid_r <= 1'b0;
      bout_r   <= 1'b0;
      baddr_r  <= '0;
      busy_r   <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      chal_r   <= chal_s;
      vote_r   <= vote_s;
      ones_r   <= ones_s;
      win_r    <= win_s;
      set_r    <= set_s;
      tie_r    <= tie_s;
      sig_r    <= sig_s;
      roen_r   <= roen_s;
      crst_r   <= crst_s;
      cen_r    <= cen_s;
      bvalid_r <= bvalid_s;
      bout_r   <= bout_s;
      baddr_r  <= baddr_s;
      busy_r   <= busy_s;
      done_r   <= done_s;
    end
  end

  assign bus.challenge   = chal_r;
  assign bus.roen        = roen_r;
  assign bus.counter_rst = crst_r;
  assign bus.counter_en  = cen_r;
  assign bus.bit_valid   = bvalid_r;
  assign bus.bit_out     = bout_r;
  assign bus.bit_addr    = baddr_r;
  assign bus.signature   = sig_r;
  assign bus.tie_cnt     = tie_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;

endmodule
